// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: 16-bit add/sub, one 4-bit carry-lookahead group per clock.
// Define ADDER_OFL_EN to register signed overflow; otherwise Ofl is tied to 0.
module nibble_serial_adder #(
   parameter int N_NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*N_NIBBLES-1:0] A,
   input  logic [4*N_NIBBLES-1:0] B,
   input  logic                   Cin,
   input  logic                   Sub,
   output logic [4*N_NIBBLES-1:0] Sum,
   output logic                   Cout,
   output logic                   Ofl,
   output logic                   busy,
   output logic                   done
);
   localparam int W = 4 * N_NIBBLES;
   localparam int NW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
   localparam logic [NW-1:0] LAST = NW'(N_NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [NW-1:0] n_q, n_d;
   logic c_q, c_d, cout_q, cout_d;
   logic [3:0] an, bn, g, p, cy;

   always_comb begin
      an = a_q[4*n_q +: 4];
      bn = b_q[4*n_q +: 4];
      g = an & bn;
      p = an ^ bn;
      cy[0] = g[0] | (p[0] & c_q);
      for (int k = 1; k < 4; k++) cy[k] = g[k] | (p[k] & cy[k-1]);
   end

   always_comb begin
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      n_d = n_q;
      sum_d = sum_q;
      cout_d = cout_q;
      case (state_q)
         IDLE: if (start) begin
            a_d = A;
            b_d = Sub ? ~B : B;
            c_d = Sub | Cin;
            n_d = '0;
            sum_d = '0;
            state_d = RUN;
         end
         RUN: begin
            sum_d[4*n_q +: 4] = p ^ {cy[2:0], c_q};
            c_d = cy[3];
            n_d = n_q + 1'b1;
            if (n_q == LAST) begin
               cout_d = cy[3];
               n_d = n_q;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         c_q <= 1'b0;
         n_q <= '0;
         sum_q <= '0;
         cout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
         n_q <= n_d;
         sum_q <= sum_d;
         cout_q <= cout_d;
      end
   end

`ifdef ADDER_OFL_EN
   logic ofl_q, ofl_d;

   always_comb begin
      ofl_d = ofl_q;
      if (state_q == RUN && n_q == LAST) ofl_d = cy[2] ^ cy[3];
   end

   always_ff @(posedge clk) begin
      if (rst) ofl_q <= 1'b0;
      else ofl_q <= ofl_d;
   end

   assign Ofl = ofl_q;
`else
   assign Ofl = 1'b0;
`endif

   assign Sum = sum_q;
   assign Cout = cout_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized self-check of nibble_serial_adder against an arithmetic model.
module tb_nibble_serial_adder;
   logic clk, rst, start, cin, sub;
   logic [15:0] a, b, sum;
   logic cout, ofl, busy, done;
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   nibble_serial_adder #(.N_NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin), .Sub(sub),
      .Sum(sum), .Cout(cout), .Ofl(ofl), .busy(busy), .done(done)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s);
      logic [15:0] yy;
      logic [16:0] full;
      logic ov;
      yy = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {16'b0, s | ci};
      ov = (x[15] == yy[15]) && (full[15] != x[15]);
`ifndef ADDER_OFL_EN
      ov = 1'b0;
`endif
      return {ov, full};
   endfunction

   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s, input bit noise);
      logic [17:0] m;
      logic [15:0] part;
      m = model(x, y, ci, s);
      @(negedge clk);
      a = x; b = y; cin = ci; sub = s; start = 1;
      @(posedge clk); #1;
      check("accept_busy", busy, 1);
      check("accept_sum", sum, 0);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         start = noise ? 1'($urandom) : 1'b0;
         if (noise) begin a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom); end
         @(posedge clk); #1;
         part = m[15:0] & 16'((32'h1 << (4*(j+1))) - 1);
         check("partial_sum", sum, part);
         check("busy", busy, j < 3);
         check("done", done, j == 3);
      end
      check("cout", cout, m[16]);
      check("ofl", ofl, m[17]);
      @(negedge clk);
      start = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      @(negedge clk);
      start = 0;
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("hold_sum", sum, m[15:0]);
      check("hold_cout", cout, m[16]);
   endtask

   task automatic wait_done(output int at);
      at = -1;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk); #1;
         if (done) begin at = cyc; break; end
      end
      check("done_timeout", at >= 0, 1);
   endtask

   initial begin
      int t1, t2;
      logic [17:0] m;
      rst = 1; start = 0; a = 0; b = 0; cin = 0; sub = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sum", sum, 0);
      check("rst_flags", {cout, ofl, busy, done}, 0);
      @(negedge clk); rst = 0;
      run_op(16'h1234, 16'h4321, 0, 0, 0);
      run_op(16'hFFFF, 16'h0001, 1, 0, 0);
      run_op(16'h7FFF, 16'h0001, 0, 0, 0);
      run_op(16'h0003, 16'h0005, 1, 1, 0);
      run_op(16'h8000, 16'h0001, 0, 1, 0);
      run_op(16'hA5A5, 16'h5A5A, 0, 0, 1);
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1; sub = 0; start = 1;
      m = model(16'h1111, 16'h2222, 1, 0);
      wait_done(t1);
      wait_done(t2);
      start = 0;
      check("b2b_spacing", t2 - t1, 6);
      check("b2b_sum", sum, m[15:0]);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("b2b_stop", busy, 0);
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0001; cin = 1; sub = 0; start = 1;
      @(posedge clk);
      @(negedge clk); start = 0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_partial", sum, 16'h0001);
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      check("abort_sum", sum, 0);
      check("abort_flags", {cout, ofl, busy, done}, 0);
      @(negedge clk); rst = 0;
      run_op(16'h0000, 16'h0000, 0, 0, 0);
      for (int i = 0; i < 40; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
